// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//
// Owns the word-addressed program counter and the instruction-fetch
// handshake. It fetches one word at a time from instruction memory and
// presents it to decode/execute. It then advances the PC on retire. The
// advance is either sequential or a taken-branch redirect. Stall holds the
// issued instruction. Halt parks the sequencer until reset.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   When defined, a FETCH that waits TIMEOUT_CYCLES cycles without an ACK
//   sets the sticky FETCH_ERR flag and parks the sequencer in HALT.
//   When undefined, FETCH waits indefinitely and FETCH_ERR is tied to 0.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   STALL        execute not ready, hold the issued instruction
//   BR_TAKEN     issued instruction redirects the PC (sampled on retire)
//   BR_TARGET    redirect word address
//   HALT_IN      stop after the current instruction or fetch
//   IMEM_REQ     fetch request to instruction memory
//   IMEM_ADDR    fetch word address (always the PC)
//   IMEM_ACK     memory returns IMEM_RDATA this cycle
//   IMEM_RDATA   fetched instruction word
//   INSTR        issued instruction
//   INSTR_VALID  INSTR and PC_OUT are valid
//   PC_OUT       PC of the issued instruction
//   HALTED       sequencer is parked in HALT
//   INSTR_COUNT  retired-instruction counter, wraps at 2^32
//   FETCH_ERR    fetch timeout flag (sticky until reset)

module pc_fetch_sequencer #(
    parameter int                    PC_WIDTH       = 30,
    parameter int                    INSTR_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR   = '0,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   STALL,
    input  logic                   BR_TAKEN,
    input  logic [PC_WIDTH-1:0]    BR_TARGET,
    input  logic                   HALT_IN,
    output logic                   IMEM_REQ,
    output logic [PC_WIDTH-1:0]    IMEM_ADDR,
    input  logic                   IMEM_ACK,
    input  logic [INSTR_WIDTH-1:0] IMEM_RDATA,
    output logic [INSTR_WIDTH-1:0] INSTR,
    output logic                   INSTR_VALID,
    output logic [PC_WIDTH-1:0]    PC_OUT,
    output logic                   HALTED,
    output logic [31:0]            INSTR_COUNT,
    output logic                   FETCH_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [PC_WIDTH-1:0]      pc;
    logic [PC_WIDTH-1:0]      pc_next;
    logic [INSTR_WIDTH-1:0]   instr;
    logic [INSTR_WIDTH-1:0]   instr_next;
    logic [31:0]              count;
    logic [31:0]              count_next;
    logic                     timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds the number of ACK-less cycles already spent in this
    // FETCH. The limit therefore trips on the TIMEOUT_CYCLES-th such cycle.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT =
        (TIMEOUT_CYCLES < 1) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              fetch_err;

    // An ACK arriving on the limit cycle wins, so only an ACK-less limit
    // cycle counts as a timeout.
    assign timeout_hit = (state == FETCH) && !IMEM_ACK && (wait_cnt == WAIT_LIMIT);

    // The wait counter is cleared whenever the sequencer is outside FETCH.
    // This gives every new fetch a fresh budget.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == FETCH && !IMEM_ACK && !timeout_hit) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                fetch_err <= 1'b1;
            end
        end
    end

    assign FETCH_ERR = fetch_err;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign FETCH_ERR          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            pc    <= RESET_VECTOR;
            instr <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            instr <= instr_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        count_next = count;

        case (state)
            IDLE: begin
                state_next = HALT_IN ? HALT : FETCH;
            end

            // The request stays up with a stable address until ACK arrives.
            // A halt request is honoured only once the fetch has completed.
            FETCH: begin
                if (IMEM_ACK) begin
                    instr_next = IMEM_RDATA;
                    state_next = HALT_IN ? HALT : ISSUE;
                end else if (timeout_hit) begin
                    state_next = HALT;
                end
            end

            // While stalled, branch and halt inputs are deliberately ignored.
            // A halting retire still applies its branch to the PC.
            ISSUE: begin
                if (!STALL) begin
                    pc_next    = BR_TAKEN ? BR_TARGET : pc + PC_WIDTH'(1);
                    count_next = count + 32'd1;
                    state_next = HALT_IN ? HALT : FETCH;
                end
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign IMEM_REQ    = (state == FETCH);
    assign IMEM_ADDR   = pc;
    assign PC_OUT      = pc;
    assign INSTR       = instr;
    assign INSTR_VALID = (state == ISSUE);
    assign HALTED      = (state == HALT);
    assign INSTR_COUNT = count;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer. The bench plays the role of instruction
// memory and the execute stage. Each fetch the bench acknowledges pushes
// the expected {pc, instr} onto a scoreboard. The entry is popped and
// compared when the sequencer presents that instruction in ISSUE.

`define CHK(tag, obs, exp) check(tag, 64'(obs), 64'(exp))

module tb_pc_fetch_sequencer;

    localparam int PW = 30;
    localparam int IW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          STALL;
    logic          BR_TAKEN;
    logic [PW-1:0] BR_TARGET;
    logic          HALT_IN;
    logic          IMEM_REQ;
    logic [PW-1:0] IMEM_ADDR;
    logic          IMEM_ACK;
    logic [IW-1:0] IMEM_RDATA;
    logic [IW-1:0] INSTR;
    logic          INSTR_VALID;
    logic [PW-1:0] PC_OUT;
    logic          HALTED;
    logic [31:0]   INSTR_COUNT;
    logic          FETCH_ERR;

    pc_fetch_sequencer #(
        .PC_WIDTH       (PW),
        .INSTR_WIDTH    (IW),
        .RESET_VECTOR   (30'd0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .STALL       (STALL),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .HALT_IN     (HALT_IN),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .PC_OUT      (PC_OUT),
        .HALTED      (HALTED),
        .INSTR_COUNT (INSTR_COUNT),
        .FETCH_ERR   (FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
    } issue_t;

    issue_t        sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] exp_pc;
    logic [31:0]   exp_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Applies reset for two cycles and checks the reset state. It then
    // releases reset and checks the single IDLE cycle that follows.
    task automatic do_reset(input logic halt_idle);
        RST = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
        HALT_IN = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = '0;
        tick();
        tick();
        `CHK("rst_req",   IMEM_REQ,    0);
        `CHK("rst_valid", INSTR_VALID, 0);
        `CHK("rst_halt",  HALTED,      0);
        `CHK("rst_cnt",   INSTR_COUNT, 0);
        `CHK("rst_pc",    PC_OUT,      0);
        `CHK("rst_instr", INSTR,       0);
        `CHK("rst_err",   FETCH_ERR,   0);
        RST = 1'b0;
        HALT_IN = halt_idle;
        `CHK("idle_req", IMEM_REQ, 0);
        tick();
        HALT_IN = 1'b0;
        exp_pc = '0;
        exp_count = '0;
        sb.delete();
    endtask

    // Acts as memory for one fetch: `waits` cycles without ACK, then ACK.
    task automatic fetch(input int waits, input logic [IW-1:0] data,
                         input logic halt, input logic br_noise);
        HALT_IN = halt;
        for (int i = 0; i <= waits; i++) begin
            `CHK("fetch_req",   IMEM_REQ,    1);
            `CHK("fetch_addr",  IMEM_ADDR,   exp_pc);
            `CHK("fetch_valid", INSTR_VALID, 0);
            `CHK("fetch_cnt",   INSTR_COUNT, exp_count);
            BR_TAKEN  = br_noise;
            BR_TARGET = 30'h2AAA;
            if (i == waits) begin
                IMEM_ACK   = 1'b1;
                IMEM_RDATA = data;
                if (!halt) sb.push_back('{pc: exp_pc, instr: data});
            end else begin
                IMEM_ACK   = 1'b0;
                IMEM_RDATA = $urandom;
            end
            tick();
        end
        IMEM_ACK = 1'b0; BR_TAKEN = 1'b0; HALT_IN = 1'b0;
    endtask

    // Acts as execute: it stalls for `stalls` cycles and then retires.
    task automatic issue(input int stalls, input logic br,
                         input logic [PW-1:0] target, input logic halt);
        issue_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i <= stalls; i++) begin
            `CHK("iss_valid", INSTR_VALID, 1);
            `CHK("iss_instr", INSTR,       e.instr);
            `CHK("iss_pc",    PC_OUT,      e.pc);
            `CHK("iss_cnt",   INSTR_COUNT, exp_count);
            `CHK("iss_req",   IMEM_REQ,    0);
            `CHK("iss_err",   FETCH_ERR,   0);
            if (i < stalls) begin
                STALL     = 1'b1;
                BR_TAKEN  = 1'($urandom);
                BR_TARGET = PW'($urandom);
                HALT_IN   = 1'($urandom);
            end else begin
                STALL     = 1'b0;
                BR_TAKEN  = br;
                BR_TARGET = target;
                HALT_IN   = halt;
            end
            tick();
        end
        exp_count = exp_count + 32'd1;
        exp_pc    = br ? target : exp_pc + PW'(1);
        STALL = 1'b0; BR_TAKEN = 1'b0; HALT_IN = 1'b0;
    endtask

    // The sequencer must stay parked with frozen PC and count while the
    // bench drives random noise on every input.
    task automatic check_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            `CHK("halt_flag",  HALTED,      1);
            `CHK("halt_req",   IMEM_REQ,    0);
            `CHK("halt_valid", INSTR_VALID, 0);
            `CHK("halt_pc",    PC_OUT,      exp_pc);
            `CHK("halt_cnt",   INSTR_COUNT, exp_count);
            IMEM_ACK  = 1'($urandom);
            STALL     = 1'($urandom);
            BR_TAKEN  = 1'($urandom);
            BR_TARGET = PW'($urandom);
            tick();
        end
        IMEM_ACK = 1'b0; STALL = 1'b0; BR_TAKEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_pc = '0;
        exp_count = '0;

        do_reset(1'b0);

        // Zero-wait memory returning its address, no stalls.
        for (int i = 0; i < 4; i++) begin
            fetch(0, IW'(exp_pc), 1'b0, 1'b0);
            issue(0, 1'b0, '0, 1'b0);
        end
        `CHK("cnt_after_4", INSTR_COUNT, 4);

        // Branch from PC=5. BR_TAKEN noise during FETCH has no effect.
        fetch(0, 32'h0000_0004, 1'b0, 1'b0);
        issue(0, 1'b0, '0, 1'b0);
        fetch(2, 32'hB5B5_0005, 1'b0, 1'b1);
        issue(0, 1'b1, 30'h100, 1'b0);

        // A 3-cycle stall with noisy branch and halt inputs.
        fetch(1, 32'h5A5A_0100, 1'b0, 1'b1);
        issue(3, 1'b0, '0, 1'b0);

        // PC wrap from the top word address.
        fetch(0, 32'h1111_0101, 1'b0, 1'b0);
        issue(0, 1'b1, 30'h3FFF_FFFF, 1'b0);
        fetch(0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(0, 1'b0, '0, 1'b0);
        `CHK("wrap_addr", IMEM_ADDR, 0);
        fetch(0, 32'h2222_0000, 1'b0, 1'b0);
        issue(0, 1'b0, '0, 1'b0);

        // HALT_IN during a slow fetch: the request is held until ACK.
        fetch(4, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check_halted(4);
        do_reset(1'b0);
        `CHK("post_halt_addr", IMEM_ADDR, 0);

        // A halting retire still applies its branch.
        fetch(0, 32'h0BAD_F00D, 1'b0, 1'b0);
        issue(0, 1'b1, 30'h55, 1'b1);
        check_halted(3);

        // HALT_IN in IDLE goes straight to HALT.
        do_reset(1'b1);
        check_halted(3);

        // An ACK on the 8th wait cycle still completes normally.
        do_reset(1'b0);
        fetch(7, 32'hCAFE_0000, 1'b0, 1'b0);
        issue(0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            `CHK("wait_req",  IMEM_REQ,  1);
            `CHK("wait_err",  FETCH_ERR, 0);
            `CHK("wait_halt", HALTED,    0);
            `CHK("wait_addr", IMEM_ADDR, exp_pc);
            tick();
        end
`ifdef FETCH_TIMEOUT_EN
        `CHK("to_err",  FETCH_ERR, 1);
        `CHK("to_halt", HALTED,    1);
        `CHK("to_req",  IMEM_REQ,  0);
        check_halted(2);
        `CHK("to_sticky", FETCH_ERR, 1);
`else
        for (int i = 0; i < 12; i++) begin
            `CHK("nto_req",  IMEM_REQ,  1);
            `CHK("nto_err",  FETCH_ERR, 0);
            `CHK("nto_halt", HALTED,    0);
            tick();
        end
`endif
        // Reset abandons any pending fetch or error.
        do_reset(1'b0);
        `CHK("final_err",  FETCH_ERR, 0);
        `CHK("final_req",  IMEM_REQ,  1);
        `CHK("final_addr", IMEM_ADDR, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
